parking_entry_arbiter: RTL and testbench

Shares the single entrance barrier and the lot's slot count among N_LANES entry lanes, each lane fronted by its own password/ticket FSM. Grants one lane at a time in round-robin order when a slot is free, reserves the slot at grant, times the barrier-open window, and decrements occupancy on exit events. Sits between the per-lane entry controllers and the barrier driver / occupancy display.

---
 rtl/parking_entry_arbiter_pkg.sv | 10 +
 rtl/parking_entry_arbiter_rr_picker.sv | 29 ++
 rtl/parking_entry_arbiter.sv | 101 ++++++++++
 tb/tb_parking_entry_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_entry_arbiter_pkg.sv
// parking_entry_arbiter_pkg: shared FSM encoding, default sizes and width helper
package parking_entry_arbiter_pkg;
   typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSE} state_e;
   localparam int DEF_N_LANES     = 2;
   localparam int DEF_CAPACITY    = 8;
   localparam int DEF_OPEN_CYCLES = 4;
   function automatic int occ_w(input int cap);
      return $clog2(cap + 1);
   endfunction
endpackage

// File: rtl/parking_entry_arbiter_rr_picker.sv
// parking_entry_arbiter_rr_picker: first requesting lane at or after the pointer, wrapping
module parking_entry_arbiter_rr_picker #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          valid_o,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o
);
   logic [IW-1:0] lane;
   // scan offsets high to low so the closest requester to the pointer wins last
   always_comb begin
      valid_o  = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      lane     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         lane = IW'((int'(ptr_i) + i) % N);
         if (req_i[lane]) begin
            valid_o        = 1'b1;
            idx_o          = lane;
            onehot_o       = '0;
            onehot_o[lane] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/parking_entry_arbiter.sv
// parking_entry_arbiter: round-robin barrier grant with slot reservation and occupancy tracking
module parking_entry_arbiter
   import parking_entry_arbiter_pkg::*;
#(
   parameter  int N_LANES     = DEF_N_LANES,
   parameter  int CAPACITY    = DEF_CAPACITY,
   parameter  int OPEN_CYCLES = DEF_OPEN_CYCLES,
   localparam int LW          = $clog2(N_LANES),
   localparam int OW          = occ_w(CAPACITY),
   localparam int TW          = $clog2(OPEN_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_LANES-1:0] entry_req,
   input  logic               exit_pulse,
   output logic [N_LANES-1:0] entry_grant,
   output logic [N_LANES-1:0] entry_deny,
   output logic               gate_open,
   output logic [LW-1:0]      active_lane,
   output logic [OW-1:0]      occupancy,
   output logic               full,
   output logic               underflow_err
);
   state_e             state_q;
   logic [N_LANES-1:0] grant_q, deny_q, pick_onehot;
   logic               gate_q, full_q, uf_q, pick_valid, fire, at_cap;
   logic [LW-1:0]      lane_q, ptr_q, pick_idx;
   logic [OW-1:0]      occ_q, occ_d;
   logic [TW-1:0]      timer_q;

   parking_entry_arbiter_rr_picker #(.N(N_LANES), .IW(LW)) u_pick (
      .req_i    (entry_req),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx)
   );

   assign fire   = (state_q == S_IDLE) && pick_valid && !full_q;
   assign at_cap = (occ_q == OW'(CAPACITY));

   // a grant reserves a slot; an exit on the same edge cancels it out
   always_comb begin
      occ_d = (fire && !exit_pulse) ? occ_q + 1'b1 :
              (!fire && exit_pulse && occ_q != '0) ? occ_q - 1'b1 : occ_q;
   end

   // barrier FSM: grant in IDLE, hold the gate for OPEN_CYCLES, one closed cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         gate_q  <= 1'b0;
         lane_q  <= '0;
         ptr_q   <= '0;
         timer_q <= '0;
      end else begin
         grant_q <= '0;
         case (state_q)
            S_IDLE: if (fire) begin
               grant_q <= pick_onehot;
               lane_q  <= pick_idx;
               ptr_q   <= (pick_idx == LW'(N_LANES - 1)) ? '0 : pick_idx + 1'b1;
               timer_q <= TW'(OPEN_CYCLES - 1);
               gate_q  <= 1'b1;
               state_q <= S_OPEN;
            end
            S_OPEN: if (timer_q == '0) begin
               gate_q  <= 1'b0;
               state_q <= S_CLOSE;
            end else begin
               timer_q <= timer_q - 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // occupancy, lot-full flag, denials and sticky underflow
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q  <= '0;
         full_q <= 1'b0;
         deny_q <= '0;
         uf_q   <= 1'b0;
      end else begin
         occ_q  <= occ_d;
         full_q <= at_cap;
         deny_q <= entry_req & {N_LANES{at_cap}};
         uf_q   <= uf_q | (exit_pulse && occ_q == '0 && !fire);
      end
   end

   assign entry_grant   = grant_q;
   assign entry_deny    = deny_q;
   assign gate_open     = gate_q;
   assign active_lane   = lane_q;
   assign occupancy     = occ_q;
   assign full          = full_q;
   assign underflow_err = uf_q;
endmodule

// File: tb/tb_parking_entry_arbiter.sv
// tb_parking_entry_arbiter: random and directed stimulus against a timeline reference model
module tb_parking_entry_arbiter;
   localparam int N   = 2;
   localparam int CAP = 8;
   localparam int OC  = 4;
   localparam int LW  = $clog2(N);
   localparam int OW  = $clog2(CAP + 1);

   typedef struct packed {
      logic [N-1:0]  grant;
      logic [N-1:0]  deny;
      logic          gate;
      logic [LW-1:0] lane;
      logic [OW-1:0] occ;
      logic          full;
      logic          uf;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [N-1:0]  entry_req = '0;
   logic          exit_pulse = 1'b0;
   logic [N-1:0]  entry_grant, entry_deny;
   logic          gate_open, full, underflow_err;
   logic [LW-1:0] active_lane;
   logic [OW-1:0] occupancy;

   int checks = 0;
   int errors = 0;

   obs_t st_q[$];
   int   gq[$];

   int           m_occ, m_ptr, m_lane, m_last, m_n;
   logic         m_full, m_uf, m_gate;
   logic [N-1:0] m_deny, m_grant;

   always #5 clk = ~clk;

   parking_entry_arbiter #(.N_LANES(N), .CAPACITY(CAP), .OPEN_CYCLES(OC)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .entry_req     (entry_req),
      .exit_pulse    (exit_pulse),
      .entry_grant   (entry_grant),
      .entry_deny    (entry_deny),
      .gate_open     (gate_open),
      .active_lane   (active_lane),
      .occupancy     (occupancy),
      .full          (full),
      .underflow_err (underflow_err)
   );

   function automatic void m_reset();
      m_occ = 0; m_ptr = 0; m_lane = 0; m_last = -1000;
      m_full = 1'b0; m_uf = 1'b0; m_gate = 1'b0;
      m_deny = '0; m_grant = '0;
   endfunction

   // one clock edge of the lot: grants need OC+2 edges since the last one, a free slot, a requester
   function automatic void m_edge(input logic [N-1:0] req, input logic ex);
      int  w;
      bit  fire, was_full;
      m_n++;
      was_full = (m_occ == CAP);
      w = -1;
      for (int k = N - 1; k >= 0; k--)
         if (req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      fire = (w >= 0) && !m_full && (m_n - m_last >= OC + 2);
      m_grant = '0;
      m_deny = was_full ? req : '0;
      if (ex && m_occ == 0 && !fire) m_uf = 1'b1;
      if (fire && !ex) m_occ++;
      else if (!fire && ex && m_occ > 0) m_occ--;
      m_full = was_full;
      if (fire) begin
         m_grant[w] = 1'b1;
         m_last = m_n;
         m_lane = w;
         m_ptr = (w + 1) % N;
         gq.push_back(w);
      end
      m_gate = (m_n - m_last) < OC;
   endfunction

   function automatic obs_t cur_obs();
      obs_t o;
      o.grant = m_grant; o.deny = m_deny; o.gate = m_gate;
      o.lane = LW'(m_lane); o.occ = OW'(m_occ); o.full = m_full; o.uf = m_uf;
      return o;
   endfunction

   task automatic step(input logic [N-1:0] req, input logic ex);
      @(negedge clk);
      reset_n = 1'b1;
      entry_req = req;
      exit_pulse = ex;
      m_edge(req, ex);
      st_q.push_back(cur_obs());
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({gate_open, entry_grant, entry_deny, occupancy, full, underflow_err, active_lane} !== '0) begin
         errors++;
         $display("FAIL %s: got gate=%b grant=%b deny=%b occ=%0d full=%b uf=%b lane=%0d, want all zero",
                  name, gate_open, entry_grant, entry_deny, occupancy, full, underflow_err, active_lane);
      end
   endtask

   task automatic reset_mid();
      @(negedge clk);
      entry_req = '0;
      exit_pulse = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_zero("async_reset");
      m_reset();
      m_n++;
      st_q.push_back(cur_obs());
   endtask

   obs_t         me, ma;
   int           mw;
   logic [N-1:0] moh;

   // monitor: pop expected grant on every DUT grant, and the per-edge status
   initial forever begin
      @(posedge clk);
      #1;
      if (entry_grant != '0) begin
         checks++;
         if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant_event @%0t: got grant=%b, want none", $time, entry_grant);
         end else begin
            mw = gq.pop_front();
            moh = '0;
            moh[mw] = 1'b1;
            if (entry_grant !== moh || active_lane !== LW'(mw)) begin
               errors++;
               $display("FAIL grant_event @%0t: got grant=%b lane=%0d, want grant=%b lane=%0d",
                        $time, entry_grant, active_lane, moh, mw);
            end
         end
      end
      if (st_q.size() != 0) begin
         me = st_q.pop_front();
         ma.grant = entry_grant; ma.deny = entry_deny; ma.gate = gate_open; ma.lane = active_lane;
         ma.occ = occupancy; ma.full = full; ma.uf = underflow_err;
         checks++;
         if (ma !== me) begin
            errors++;
            $display("FAIL status @%0t: got grant=%b deny=%b gate=%b lane=%0d occ=%0d full=%b uf=%b, want grant=%b deny=%b gate=%b lane=%0d occ=%0d full=%b uf=%b",
                     $time, ma.grant, ma.deny, ma.gate, ma.lane, ma.occ, ma.full, ma.uf,
                     me.grant, me.deny, me.gate, me.lane, me.occ, me.full, me.uf);
         end
      end
   end

   logic [N-1:0] rreq;

   initial begin
      m_reset();
      m_n = 0;
      @(posedge clk);
      #1 check_zero("reset_values");
      step('0, 1'b1);
      repeat (3) step('0, 1'b0);
      repeat (8) step(2'b01, 1'b0);
      repeat (24) step(2'b11, 1'b0);
      for (int i = 0; i < 10 && !m_gate; i++) step(2'b01, 1'b0);
      step(2'b01, 1'b0);
      reset_mid();
      repeat (8) step(2'b11, 1'b0);
      repeat (70) step(2'b11, 1'b0);
      repeat (5) step(2'b10, 1'b0);
      step(2'b10, 1'b1);
      repeat (10) step(2'b10, 1'b0);
      reset_mid();
      for (int i = 0; i < 40 && m_occ < 3; i++) step(2'b01, 1'b0);
      for (int i = 0; i < 10 && (m_n + 1 - m_last < OC + 2); i++) step('0, 1'b0);
      step(2'b01, 1'b1);
      repeat (8) step('0, 1'b0);
      rreq = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rreq = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 999) == 0) reset_mid();
         else step(rreq, ($urandom_range(0, ((i / 400) % 2 == 1) ? 3 : 30) == 0));
      end
      repeat (3) step('0, 1'b0);
      @(posedge clk);
      #2;
      checks++;
      if (gq.size() != 0 || st_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d grants and %0d status entries pending, want 0 and 0",
                  gq.size(), st_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
